// File: rtl/bus_master_bridge.sv
// Single-outstanding bridge from the CPU load/store port to the word-addressed system bus.
// Reports slave errors and response timeouts to the interrupt controller before completing with error.
module bus_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_write,
    input  logic [29:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    input  logic [3:0]  cpu_req_byteenable,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_error,
    output logic [29:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic [4:0]  m_burstcount,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_writeresponsevalid,
    input  logic [1:0]  m_response,
    output logic [31:0] badAddr,
    output logic        badAddrValid,
    input  logic        badAddrAck
);

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RESP_WAIT,
        ERR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [BW-1:0]     be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              bad_valid_q, bad_valid_d;
    logic [DW-1:0]     bad_addr_q, bad_addr_d;
    logic              rsp_hit;
    logic              timeout;

    // Only the strobe matching the outstanding command direction counts as a response.
    assign rsp_hit = wr_q ? m_writeresponsevalid : m_readdatavalid;
    assign timeout = (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid && ready_q) begin
                    wr_d    = cpu_req_write;
                    addr_d  = cpu_req_addr;
                    wdata_d = cpu_req_wdata;
                    be_d    = cpu_req_byteenable;
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    state_d = ERR;
                end else if (!m_waitrequest) begin
                    state_d = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the timeout cycle still wins.
                if (rsp_hit) begin
                    if (m_response == 2'b00) begin
                        state_d     = DONE;
                        rsp_rdata_d = wr_q ? '0 : m_readdata;
                    end else begin
                        state_d = ERR;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (badAddrAck) begin
                    state_d   = DONE;
                    rsp_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m_read_d    = (state_d == CMD) && !wr_d;
        m_write_d   = (state_d == CMD) && wr_d;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        bad_valid_d = (state_d == ERR);
        bad_addr_d  = bad_valid_d ? {addr_d, 2'b00} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            bad_valid_q <= 1'b0;
            bad_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bad_valid_q <= bad_valid_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    assign cpu_req_ready = ready_q;
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign cpu_rsp_error = rsp_err_q;
    assign m_address     = addr_q;
    assign m_read        = m_read_q;
    assign m_write       = m_write_q;
    assign m_writedata   = wdata_q;
    assign m_byteenable  = be_q;
    assign m_burstcount  = 5'd1;
    assign badAddr       = bad_addr_q;
    assign badAddrValid  = bad_valid_q;

endmodule

// File: doc/bus_master_bridge.md
Name: bus_master_bridge

Overview:
- Single-outstanding bus initiator between the CPU load/store port and the 32-bit word-addressed system bus.
- Converts one CPU request at a time into one single-beat read or write command, waits for the slave's response, and returns data or error to the CPU.
- On a slave error response or a timeout, reports the faulting byte address to the interrupt controller over its badAddr/badAddrValid/badAddrAck handshake, then completes the CPU access with an error.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed from command issue to response before the access is declared failed; legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  bridge accepts a request this cycle
- cpu_req_write  in  1  1 = write, 0 = read
- cpu_req_addr  in  30  word address
- cpu_req_wdata  in  32  write data
- cpu_req_byteenable  in  4  byte lanes
- cpu_rsp_valid  out  1  one-cycle completion pulse
- cpu_rsp_rdata  out  32  read data; 0 for writes and errors
- cpu_rsp_error  out  1  access failed
- m_address  out  30  bus word address
- m_read  out  1  read command
- m_write  out  1  write command
- m_writedata  out  32  bus write data
- m_byteenable  out  4  bus byte enables
- m_burstcount  out  5  constant 1
- m_waitrequest  in  1  slave stalls the command
- m_readdata  in  32  slave read data
- m_readdatavalid  in  1  read response strobe
- m_writeresponsevalid  in  1  write response strobe
- m_response  in  2  00 = OK; any other value = error
- badAddr  out  32  faulting byte address, {addr, 2'b00}
- badAddrValid  out  1  fault report pending
- badAddrAck  in  1  interrupt controller has latched the report

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0 except m_burstcount = 1; the timeout counter is cleared.
- Reset asserted mid-transaction abandons the access. No cpu_rsp_valid and no badAddrValid are produced.

State machine:
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch write/addr/wdata/byteenable and go to CMD.
  - Bus responses arriving in IDLE, such as late responses after a timeout, are ignored.
- CMD:
  - Assert m_read or m_write (never both), driving the latched address, data and enables.
  - All command signals are held stable while m_waitrequest = 1.
  - The command is accepted in the first CMD cycle with m_waitrequest = 0; go to RESP_WAIT next cycle.
  - Minimum: command visible 1 cycle after the accept.
- RESP_WAIT:
  - Command signals are deasserted.
  - For a read, wait for m_readdatavalid; for a write, wait for m_writeresponsevalid. The other strobe is ignored.
  - On the matching strobe:
    - If m_response = 00, capture m_readdata (reads only) and go to DONE.
    - Otherwise go to ERR.
- Timeout:
  - The counter is cleared on entry to CMD and increments every cycle in CMD and RESP_WAIT.
  - When it reaches TIMEOUT_CYCLES without a matching strobe, deassert the command immediately and go to ERR.
  - A response arriving in the same cycle the count reaches TIMEOUT_CYCLES takes priority: the access completes normally.
- ERR:
  - badAddrValid = 1 and badAddr = {latched addr, 2'b00}, both held until a cycle with badAddrAck = 1.
  - In that cycle, go to DONE with the error flag set. badAddrValid drops the following cycle.
  - badAddrAck outside ERR is ignored.
- DONE:
  - cpu_rsp_valid = 1 for exactly one cycle, with cpu_rsp_rdata and cpu_rsp_error valid in that cycle.
  - Return to IDLE. cpu_req_ready rises the following cycle, so there is no back-to-back acceptance in DONE.
- The CPU side has no backpressure: the CPU must sample cpu_rsp_valid in its pulse cycle.
- Latency:
  - Zero-wait read with a 1-cycle registered slave: accept at cycle 0, command at cycle 1, response at cycle 2, cpu_rsp_valid at cycle 3.
  - Each slave wait state adds 1 cycle.

Test Plan:
- Read addr 0x3E00C004, slave returns 0xDEADBEEF with response 00 one cycle after acceptance → m_read held 1 cycle; cpu_rsp_valid at cycle 3 with rdata = 0xDEADBEEF, error = 0; badAddrValid stays 0.
- Write 0x12345678 with byteenable 0xF, m_waitrequest held high 3 cycles → m_write, m_address and m_writedata stable for 4 cycles; writeresponsevalid with response 00 → cpu_rsp_valid with error = 0, rdata = 0.
- Read addr 0x00000010, slave responds 2'b11 → badAddr = 0x00000040 and badAddrValid held until badAddrAck (asserted after 5 cycles) → cpu_rsp_valid with error = 1, rdata = 0.
- Read to an unmapped address with no response and TIMEOUT_CYCLES = 8 → command dropped after 8 cycles, ERR entered, badAddr reported, error completion; a readdatavalid injected 4 cycles later is ignored and the next request completes normally.
- rst pulsed while in RESP_WAIT → all outputs return to reset values asynchronously; no rsp pulse; the following request succeeds.
- Response strobe in exactly the cycle the counter hits TIMEOUT_CYCLES → normal completion, no badAddrValid.
